// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared opcode, funct3, stall and EX/MEM definitions
// Purpose: constants and types shared by the execute stage and its ALU.
// Contents: RV32I opcodes, funct3 codes, ZeroWord, stall bit indices/masks,
//           the EX/MEM register layout and its bubble value.
package ex_stage_pkg;

   // RV32I major opcodes
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] ALOPI  = 7'b0010011;
   localparam logic [6:0] ALOP   = 7'b0110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] ADDI    = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Stall vector layout
   localparam int         STALL_IF       = 0;
   localparam int         STALL_ID       = 1;
   localparam int         STALL_MEM      = 2;
   localparam logic [2:0] STALL_MASK_IF  = 3'b001;
   localparam logic [2:0] STALL_MASK_ID  = 3'b010;
   localparam logic [2:0] STALL_MASK_MEM = 3'b100;

   typedef struct packed {
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic [31:0] mem_addr;
      logic [31:0] store_data;
      logic [6:0]  ins_type;
      logic [2:0]  ins_details;
      logic        wb_enable;
   } exmem_t;

   // A bubble decodes as "addi x0, x0, 0" with writeback disabled
   localparam exmem_t EXMEM_BUBBLE = '{
      rd_addr:     5'd0,
      rd_data:     ZeroWord,
      mem_addr:    ZeroWord,
      store_data:  ZeroWord,
      ins_type:    ALOPI,
      ins_details: ADDI,
      wb_enable:   1'b0
   };

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational RV32I integer ALU
// Purpose: computes the ALU result for register and immediate operations.
// Ports:
//   op1_i, op2_i  32-bit operands (op2 also supplies the shift amount)
//   funct3_i      operation select
//   diff_i        selects SUB for funct3 000 and SRA for funct3 101
//   result_o      32-bit result, wrap-around arithmetic
module ex_stage_alu
   import ex_stage_pkg::*;
(
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [2:0]  funct3_i,
   input  logic        diff_i,
   output logic [31:0] result_o
);

   logic [4:0] shamt;
   assign shamt = op2_i[4:0];

   always_comb begin
      result_o = ZeroWord;
      case (funct3_i)
         F3_ADD:  result_o = diff_i ? (op1_i - op2_i) : (op1_i + op2_i);
         F3_SLL:  result_o = op1_i << shamt;
         F3_SLT:  result_o = {31'b0, ($signed(op1_i) < $signed(op2_i))};
         F3_SLTU: result_o = {31'b0, (op1_i < op2_i)};
         F3_XOR:  result_o = op1_i ^ op2_i;
         F3_SR:   result_o = diff_i ? 32'($signed(op1_i) >>> shamt) : (op1_i >> shamt);
         F3_OR:   result_o = op1_i | op2_i;
         F3_AND:  result_o = op1_i & op2_i;
         default: result_o = ZeroWord;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage with EX/MEM register
// Purpose: ALU, branch and jump resolution, EX forwarding, IF redirect and
//          the EX/MEM pipeline register.
// Ports:
//   clk_in, rst_in, rdy_in    clock, sync active-high reset, global enable
//   clear, stall              flush to bubble / stall vector (STALL_MEM freezes)
//   pc, r1_data, r2_data, imm, rd_addr, ins_type, ins_details, ins_diff
//                             decoded operands from ID/EX
//   forward_ex_*              combinational forwarding bus to ID/EX
//   jump_enable, jump_addr    combinational redirect request to IF
//   output_*                  registered EX/MEM fields for the memory stage
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic [2:0]  stall,
   input  logic [31:0] pc,
   input  logic [31:0] r1_data,
   input  logic [31:0] r2_data,
   input  logic [31:0] imm,
   input  logic [4:0]  rd_addr,
   input  logic [6:0]  ins_type,
   input  logic [2:0]  ins_details,
   input  logic        ins_diff,
   output logic        forward_ex_enable,
   output logic [4:0]  forward_ex_addr,
   output logic [31:0] forward_ex_data,
   output logic        forward_ex_is_load,
   output logic        jump_enable,
   output logic [31:0] jump_addr,
   output logic [4:0]  output_rd_addr,
   output logic [31:0] output_rd_data,
   output logic [31:0] output_mem_addr,
   output logic [31:0] output_store_data,
   output logic [6:0]  output_ins_type,
   output logic [2:0]  output_ins_details,
   output logic        output_wb_enable
);

   logic        stall_mem;
   logic        unused_stall;
   logic [31:0] alu_op2;
   logic        alu_diff;
   logic [31:0] alu_result;
   logic [31:0] pc_imm;
   logic [31:0] pc_plus4;
   logic [31:0] r1_imm;
   logic        taken;
   logic [31:0] target;
   logic [31:0] rd_data;
   logic        wb_eligible;
   logic        redirect_done_q;
   logic        redirect_done_d;
   exmem_t      ex_mem_d;
   exmem_t      ex_mem_q;

   assign stall_mem    = stall[STALL_MEM];
   assign unused_stall = ^(stall & ~STALL_MASK_MEM);

   assign pc_imm   = pc + imm;
   assign pc_plus4 = pc + 32'd4;
   assign r1_imm   = r1_data + imm;

   // funct7[5] means SUB only for register ops; SRA/SRAI use it for both forms
   assign alu_op2  = (ins_type == ALOP) ? r2_data : imm;
   assign alu_diff = ins_diff & ((ins_type == ALOP) | (ins_details == F3_SR));

   ex_stage_alu u_alu (
      .op1_i    (r1_data),
      .op2_i    (alu_op2),
      .funct3_i (ins_details),
      .diff_i   (alu_diff),
      .result_o (alu_result)
   );

   // Branch resolution and redirect target; IF always predicts not-taken
   always_comb begin
      taken  = 1'b0;
      target = ZeroWord;
      case (ins_type)
         BRANCH: begin
            target = pc_imm;
            case (ins_details)
               F3_BEQ:  taken = (r1_data == r2_data);
               F3_BNE:  taken = (r1_data != r2_data);
               F3_BLT:  taken = ($signed(r1_data) <  $signed(r2_data));
               F3_BGE:  taken = ($signed(r1_data) >= $signed(r2_data));
               F3_BLTU: taken = (r1_data <  r2_data);
               F3_BGEU: taken = (r1_data >= r2_data);
               default: taken = 1'b0;
            endcase
         end
         JAL: begin
            taken  = 1'b1;
            target = pc_imm;
         end
         JALR: begin
            taken  = 1'b1;
            target = {r1_imm[31:1], 1'b0};
         end
         default: ;
      endcase
   end

   // Writeback value; loads, stores and branches produce nothing here
   always_comb begin
      rd_data = ZeroWord;
      case (ins_type)
         LUI:         rd_data = imm;
         AUIPC:       rd_data = pc_imm;
         JAL, JALR:   rd_data = pc_plus4;
         ALOP, ALOPI: rd_data = alu_result;
         default:     rd_data = ZeroWord;
      endcase
   end

   assign wb_eligible = (rd_addr != 5'd0) && (ins_type != STORE) && (ins_type != BRANCH);

   assign forward_ex_enable  = wb_eligible && (ins_type != LOAD);
   assign forward_ex_addr    = rd_addr;
   assign forward_ex_data    = rd_data;
   assign forward_ex_is_load = (ins_type == LOAD);

   // A frozen instruction keeps presenting its jump; only the first cycle redirects
   assign jump_enable = taken && !redirect_done_q;
   assign jump_addr   = target;

   always_comb begin
      redirect_done_d = redirect_done_q;
      if (rdy_in) begin
         if (stall_mem) begin
            if (jump_enable) begin
               redirect_done_d = 1'b1;
            end
         end else begin
            redirect_done_d = 1'b0;
         end
      end
   end

   always_comb begin
      ex_mem_d             = EXMEM_BUBBLE;
      ex_mem_d.rd_addr     = rd_addr;
      ex_mem_d.rd_data     = rd_data;
      ex_mem_d.mem_addr    = ((ins_type == LOAD) || (ins_type == STORE)) ? r1_imm : ZeroWord;
      ex_mem_d.store_data  = r2_data;
      ex_mem_d.ins_type    = ins_type;
      ex_mem_d.ins_details = ins_details;
      ex_mem_d.wb_enable   = wb_eligible;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ex_mem_q        <= EXMEM_BUBBLE;
         redirect_done_q <= 1'b0;
      end else begin
         redirect_done_q <= redirect_done_d;
         if (rdy_in && !stall_mem) begin
            ex_mem_q <= clear ? EXMEM_BUBBLE : ex_mem_d;
         end
      end
   end

   assign output_rd_addr     = ex_mem_q.rd_addr;
   assign output_rd_data     = ex_mem_q.rd_data;
   assign output_mem_addr    = ex_mem_q.mem_addr;
   assign output_store_data  = ex_mem_q.store_data;
   assign output_ins_type    = ex_mem_q.ins_type;
   assign output_ins_details = ex_mem_q.ins_details;
   assign output_wb_enable   = ex_mem_q.wb_enable;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear;
   logic [2:0]  stall;
   logic [31:0] pc, r1_data, r2_data, imm;
   logic [4:0]  rd_addr;
   logic [6:0]  ins_type;
   logic [2:0]  ins_details;
   logic        ins_diff;
   logic        forward_ex_enable, forward_ex_is_load, jump_enable, output_wb_enable;
   logic [4:0]  forward_ex_addr, output_rd_addr;
   logic [31:0] forward_ex_data, jump_addr, output_rd_data, output_mem_addr, output_store_data;
   logic [6:0]  output_ins_type;
   logic [2:0]  output_ins_details;

   always #5 clk_in = ~clk_in;

   ex_stage dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .stall(stall),
      .pc(pc), .r1_data(r1_data), .r2_data(r2_data), .imm(imm), .rd_addr(rd_addr),
      .ins_type(ins_type), .ins_details(ins_details), .ins_diff(ins_diff),
      .forward_ex_enable(forward_ex_enable), .forward_ex_addr(forward_ex_addr),
      .forward_ex_data(forward_ex_data), .forward_ex_is_load(forward_ex_is_load),
      .jump_enable(jump_enable), .jump_addr(jump_addr),
      .output_rd_addr(output_rd_addr), .output_rd_data(output_rd_data),
      .output_mem_addr(output_mem_addr), .output_store_data(output_store_data),
      .output_ins_type(output_ins_type), .output_ins_details(output_ins_details),
      .output_wb_enable(output_wb_enable)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] rd_data;
      logic [31:0] mem_addr;
      logic [31:0] jaddr;
      logic        taken;
      logic        wb;
      logic        fwd;
      logic        is_load;
   } mres_t;

   function automatic mres_t model_comb();
      mres_t       m;
      logic [31:0] a, b;
      int          sa, sb, sh;
      m = '0;
      a = r1_data;
      b = (ins_type == ALOP) ? r2_data : imm;
      sh = int'(b[4:0]);
      case (ins_type)
         LUI:   m.rd_data = imm;
         AUIPC: m.rd_data = pc + imm;
         JAL:   begin m.rd_data = pc + 4; m.taken = 1'b1; m.jaddr = pc + imm; end
         JALR:  begin m.rd_data = pc + 4; m.taken = 1'b1; m.jaddr = (r1_data + imm) & 32'hFFFF_FFFE; end
         ALOP, ALOPI: begin
            sa = a; sb = b;
            case (ins_details)
               3'd0: m.rd_data = (ins_type == ALOP && ins_diff) ? a - b : a + b;
               3'd1: m.rd_data = a << sh;
               3'd2: m.rd_data = (sa < sb) ? 32'd1 : 32'd0;
               3'd3: m.rd_data = (a < b) ? 32'd1 : 32'd0;
               3'd4: m.rd_data = a ^ b;
               3'd5: m.rd_data = (a >> sh) | ((ins_diff && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
               3'd6: m.rd_data = a | b;
               default: m.rd_data = a & b;
            endcase
         end
         BRANCH: begin
            sa = r1_data; sb = r2_data;
            m.jaddr = pc + imm;
            case (ins_details)
               3'd0: m.taken = (r1_data == r2_data);
               3'd1: m.taken = (r1_data != r2_data);
               3'd4: m.taken = (sa < sb);
               3'd5: m.taken = (sa >= sb);
               3'd6: m.taken = (r1_data < r2_data);
               3'd7: m.taken = (r1_data >= r2_data);
               default: m.taken = 1'b0;
            endcase
         end
         default: ;
      endcase
      if (ins_type == LOAD || ins_type == STORE) m.mem_addr = r1_data + imm;
      m.wb      = (rd_addr != 0) && (ins_type != STORE) && (ins_type != BRANCH);
      m.is_load = (ins_type == LOAD);
      m.fwd     = m.wb && !m.is_load;
      return m;
   endfunction

   logic        m_valid = 1'b0;
   logic        m_done  = 1'b0;
   logic [4:0]  e_rd_addr;
   logic [31:0] e_rd_data, e_mem_addr, e_store;
   logic [6:0]  e_type;
   logic [2:0]  e_det;
   logic        e_wb;

   task automatic model_bubble();
      e_rd_addr = 0; e_rd_data = 0; e_mem_addr = 0; e_store = 0;
      e_type = 7'b0010011; e_det = 3'b000; e_wb = 1'b0;
   endtask

   mres_t pm;
   logic  jump_now;
   always @(posedge clk_in) begin
      pm = model_comb();
      jump_now = pm.taken && !m_done;
      if (rst_in) begin
         m_done = 1'b0;
         model_bubble();
         m_valid = 1'b1;
      end else if (rdy_in) begin
         if (stall[2]) begin
            if (jump_now) m_done = 1'b1;
         end else begin
            m_done = 1'b0;
            if (clear) model_bubble();
            else begin
               e_rd_addr = rd_addr; e_rd_data = pm.rd_data; e_mem_addr = pm.mem_addr;
               e_store = r2_data; e_type = ins_type; e_det = ins_details; e_wb = pm.wb;
            end
         end
      end
   end

   mres_t cm;
   always @(negedge clk_in) begin
      if (m_valid) begin
         cm = model_comb();
         chk("fwd_enable", {31'b0, forward_ex_enable}, {31'b0, cm.fwd});
         chk("fwd_addr", {27'b0, forward_ex_addr}, {27'b0, rd_addr});
         if (cm.fwd) chk("fwd_data", forward_ex_data, cm.rd_data);
         chk("fwd_is_load", {31'b0, forward_ex_is_load}, {31'b0, cm.is_load});
         chk("jump_enable", {31'b0, jump_enable}, {31'b0, cm.taken && !m_done});
         if (cm.taken && !m_done) chk("jump_addr", jump_addr, cm.jaddr);
         chk("out_rd_addr", {27'b0, output_rd_addr}, {27'b0, e_rd_addr});
         chk("out_rd_data", output_rd_data, e_rd_data);
         chk("out_mem_addr", output_mem_addr, e_mem_addr);
         chk("out_store_data", output_store_data, e_store);
         chk("out_ins_type", {25'b0, output_ins_type}, {25'b0, e_type});
         chk("out_ins_details", {29'b0, output_ins_details}, {29'b0, e_det});
         chk("out_wb_enable", {31'b0, output_wb_enable}, {31'b0, e_wb});
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] p, input logic [4:0] rd);
      ins_type = op; ins_details = f3; ins_diff = d;
      r1_data = a; r2_data = b; imm = im; pc = p; rd_addr = rd;
   endtask

   task automatic bubble_in();
      drive(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0, 5'd0);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        d;
      logic [31:0] a, b, im, p, exp;
   } vec_t;

   vec_t alu_tbl[14];
   vec_t br_tbl[6];

   initial begin
      alu_tbl[0]  = '{7'b0110011, 3'd0, 1'b0, 32'd3,         32'd4,      32'd0,          32'd0,     32'd7};
      alu_tbl[1]  = '{7'b0110011, 3'd0, 1'b1, 32'd5,         32'd7,      32'd0,          32'd0,     32'hFFFF_FFFE};
      alu_tbl[2]  = '{7'b0010011, 3'd0, 1'b1, 32'd10,        32'd0,      32'd5,          32'd0,     32'd15};
      alu_tbl[3]  = '{7'b0110011, 3'd1, 1'b0, 32'd1,         32'h23,     32'd0,          32'd0,     32'd8};
      alu_tbl[4]  = '{7'b0110011, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1,      32'd0,          32'd0,     32'd1};
      alu_tbl[5]  = '{7'b0110011, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1,      32'd0,          32'd0,     32'd0};
      alu_tbl[6]  = '{7'b0010011, 3'd4, 1'b0, 32'h0000_F0F0, 32'd0,      32'hFFFF_FFFF,  32'd0,     32'hFFFF_0F0F};
      alu_tbl[7]  = '{7'b0110011, 3'd5, 1'b0, 32'h8000_0000, 32'd4,      32'd0,          32'd0,     32'h0800_0000};
      alu_tbl[8]  = '{7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd0,      32'd4,          32'd0,     32'hF800_0000};
      alu_tbl[9]  = '{7'b0110011, 3'd6, 1'b0, 32'h0F,        32'hF0,     32'd0,          32'd0,     32'hFF};
      alu_tbl[10] = '{7'b0010011, 3'd7, 1'b0, 32'h1234,      32'd0,      32'hFF,         32'd0,     32'h34};
      alu_tbl[11] = '{7'b0110011, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1,      32'd0,          32'd0,     32'd0};
      alu_tbl[12] = '{7'b0110111, 3'd0, 1'b0, 32'd0,         32'd0,      32'h1234_5000,  32'd0,     32'h1234_5000};
      alu_tbl[13] = '{7'b0010111, 3'd0, 1'b0, 32'd0,         32'd0,      32'h1000,       32'h100,   32'h1100};

      // exp holds 1 for taken, 0 for not taken
      br_tbl[0] = '{7'b1100011, 3'd0, 1'b0, 32'd3,         32'd3, 32'h20, 32'h100, 32'd1};
      br_tbl[1] = '{7'b1100011, 3'd1, 1'b0, 32'd3,         32'd3, 32'h20, 32'h100, 32'd0};
      br_tbl[2] = '{7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd1};
      br_tbl[3] = '{7'b1100011, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0};
      br_tbl[4] = '{7'b1100011, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0};
      br_tbl[5] = '{7'b1100011, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd1};

      rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; stall = 3'b000;
      bubble_in();
      step(); step();
      @(negedge clk_in);
      chk("reset_rd_addr", {27'b0, output_rd_addr}, 32'd0);
      chk("reset_ins_type", {25'b0, output_ins_type}, 32'h13);
      chk("reset_wb", {31'b0, output_wb_enable}, 32'd0);
      step();
      rst_in = 1'b0;

      // ALU and immediate/upper ops
      for (int i = 0; i < 14; i++) begin
         drive(alu_tbl[i].op, alu_tbl[i].f3, alu_tbl[i].d, alu_tbl[i].a, alu_tbl[i].b,
               alu_tbl[i].im, alu_tbl[i].p, 5'd1);
         @(negedge clk_in);
         chk("alu_table", forward_ex_data, alu_tbl[i].exp);
         step();
      end

      // SUB then registered result
      drive(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1);
      @(negedge clk_in);
      chk("sub_fwd", forward_ex_data, 32'hFFFF_FFFE);
      step();
      bubble_in();
      @(negedge clk_in);
      chk("sub_out", output_rd_data, 32'hFFFF_FFFE);
      chk("sub_wb", {31'b0, output_wb_enable}, 32'd1);
      step();

      // BEQ taken
      drive(7'b1100011, 3'd0, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100, 5'd7);
      @(negedge clk_in);
      chk("beq_jump", {31'b0, jump_enable}, 32'd1);
      chk("beq_addr", jump_addr, 32'h120);
      step();
      bubble_in();
      @(negedge clk_in);
      chk("beq_wb", {31'b0, output_wb_enable}, 32'd0);
      step();

      for (int i = 0; i < 6; i++) begin
         drive(br_tbl[i].op, br_tbl[i].f3, br_tbl[i].d, br_tbl[i].a, br_tbl[i].b,
               br_tbl[i].im, br_tbl[i].p, 5'd0);
         @(negedge clk_in);
         chk("branch_table", {31'b0, jump_enable}, br_tbl[i].exp);
         step();
      end

      // JALR frozen for three cycles: single redirect
      drive(7'b1100111, 3'd0, 1'b0, 32'h1003, 32'd0, 32'd0, 32'h40, 5'd1);
      stall = 3'b100;
      @(negedge clk_in);
      chk("jalr_jump_first", {31'b0, jump_enable}, 32'd1);
      chk("jalr_addr", jump_addr, 32'h1002);
      step();
      @(negedge clk_in);
      chk("jalr_jump_2", {31'b0, jump_enable}, 32'd0);
      step();
      @(negedge clk_in);
      chk("jalr_jump_3", {31'b0, jump_enable}, 32'd0);
      step();
      stall = 3'b000;
      @(negedge clk_in);
      chk("jalr_jump_release", {31'b0, jump_enable}, 32'd0);
      step();
      bubble_in();
      @(negedge clk_in);
      chk("jalr_link", output_rd_data, 32'h44);
      step();

      // LOAD
      drive(7'b0000011, 3'd2, 1'b0, 32'h200, 32'd0, 32'hFFFF_FFFC, 32'd0, 5'd5);
      @(negedge clk_in);
      chk("load_fwd_en", {31'b0, forward_ex_enable}, 32'd0);
      chk("load_is_load", {31'b0, forward_ex_is_load}, 32'd1);
      step();
      bubble_in();
      @(negedge clk_in);
      chk("load_mem_addr", output_mem_addr, 32'h1FC);
      step();

      // STORE: no writeback even with nonzero rd field
      drive(7'b0100011, 3'd2, 1'b0, 32'h300, 32'hCAFE, 32'd8, 32'd0, 5'd9);
      step();
      bubble_in();
      @(negedge clk_in);
      chk("store_data", output_store_data, 32'hCAFE);
      chk("store_wb", {31'b0, output_wb_enable}, 32'd0);
      step();

      // clear flushes ADD
      drive(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      bubble_in();
      @(negedge clk_in);
      chk("clear_rd", {27'b0, output_rd_addr}, 32'd0);
      chk("clear_wb", {31'b0, output_wb_enable}, 32'd0);
      step();

      // clear with JAL still redirects
      drive(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h10, 32'h80, 5'd1);
      clear = 1'b1;
      @(negedge clk_in);
      chk("clear_jal_jump", {31'b0, jump_enable}, 32'd1);
      chk("clear_jal_addr", jump_addr, 32'h90);
      step();
      clear = 1'b0;
      bubble_in();
      step();

      // rdy_in low holds EX/MEM
      drive(7'b0010011, 3'd0, 1'b0, 32'd9, 32'd0, 32'd1, 32'd0, 5'd4);
      rdy_in = 1'b0;
      step();
      @(negedge clk_in);
      chk("rdy_hold_rd", {27'b0, output_rd_addr}, 32'd0);
      rdy_in = 1'b1;
      step();
      bubble_in();
      @(negedge clk_in);
      chk("rdy_release", output_rd_data, 32'd10);
      step();

      // rdy_in low keeps redirect_done
      drive(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h8, 32'h300, 5'd1);
      stall = 3'b100;
      step();
      rdy_in = 1'b0;
      step();
      rdy_in = 1'b1;
      @(negedge clk_in);
      chk("rdy_done_hold", {31'b0, jump_enable}, 32'd0);
      stall = 3'b000;
      step();
      bubble_in();
      step();

      // reset during a frozen jump clears redirect_done
      drive(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h8, 32'h400, 5'd2);
      stall = 3'b100;
      @(negedge clk_in);
      chk("frz_jump", {31'b0, jump_enable}, 32'd1);
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      drive(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h8, 32'h200, 5'd2);
      @(negedge clk_in);
      chk("rst_bubble_type", {25'b0, output_ins_type}, 32'h13);
      chk("rst_new_jump", {31'b0, jump_enable}, 32'd1);
      chk("rst_new_addr", jump_addr, 32'h208);
      step();
      stall = 3'b000;
      bubble_in();
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
